// File: rtl/pipeline_ctrl_pkg.sv
// Shared decode helpers, state encoding and scoreboard entry type
// for the five-stage pipeline controller.
package pipeline_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
    } sb_entry_t;

    // A $0 destination is reported as invalid so it never hazards.
    function automatic sb_entry_t get_dest(input logic [31:0] instr);
        sb_entry_t e;
        e.dest = 5'd0;
        case (instr[31:26])
            OP_RTYPE: e.dest = instr[15:11];
            OP_LW, OP_ADDI, OP_ANDI,
            OP_ORI, OP_SLTI, OP_LUI: e.dest = instr[20:16];
            OP_BEQ, OP_BNE, OP_SW, OP_J: e.dest = 5'd0;
            default: e.dest = 5'd0;
        endcase
        e.valid = (e.dest != 5'd0);
        return e;
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/pipeline_controller_hazard_scoreboard.sv
// Three-entry destination scoreboard (EX, MEM, WB) with the
// same-cycle RAW compare against the IF/ID sources.
module hazard_scoreboard
    import pipeline_ctrl_pkg::*;
#(
    parameter bit WRITE_THROUGH = 1'b1
) (
    input  logic      clock,
    input  logic      reset,
    input  sb_entry_t id_dest,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic      rt_used,
    input  logic      id_ex_flush,
    input  logic      ex_mem_flush,
    output logic      hazard
);

    sb_entry_t sb_ex;
    sb_entry_t sb_mem;
    sb_entry_t sb_wb;

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_wb  <= sb_mem;
            sb_mem <= ex_mem_flush ? '0 : sb_ex;
            sb_ex  <= id_ex_flush ? '0 : id_dest;
        end
    end

    function automatic logic hit(input sb_entry_t e, input logic [4:0] r);
        return e.valid && (r != 5'd0) && (e.dest == r);
    endfunction

    logic [2:0] rs_hit;
    logic [2:0] rt_hit;

    always_comb begin
        rs_hit = {hit(sb_wb, rs), hit(sb_mem, rs), hit(sb_ex, rs)};
        rt_hit = {hit(sb_wb, rt), hit(sb_mem, rt), hit(sb_ex, rt)};
        if (!rt_used) rt_hit = 3'b000;
        // With a write-through register file the WB producer is visible
        // to the ID read in the same cycle.
        if (WRITE_THROUGH) begin
            rs_hit[2] = 1'b0;
            rt_hit[2] = 1'b0;
        end
        hazard = |(rs_hit | rt_hit);
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencing: RAW stalls, branch redirect flushes and the
// halt/drain state machine, plus the stall performance counter.
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter bit REGFILE_WRITE_THROUGH = 1'b1,
    parameter int DRAIN_CYCLES          = 3,
    parameter int CNT_W                 = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      id_instruction,
    input  logic             mem_shouldBranch,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             stall,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_next;
    logic          hazard;
    logic          unused_bits;

    assign unused_bits = ^id_instruction[10:0];

    hazard_scoreboard #(
        .WRITE_THROUGH(REGFILE_WRITE_THROUGH)
    ) u_sb (
        .clock       (clock),
        .reset       (reset),
        .id_dest     (get_dest(id_instruction)),
        .rs          (id_instruction[25:21]),
        .rt          (id_instruction[20:16]),
        .rt_used     (uses_rt(id_instruction[31:26])),
        .id_ex_flush (id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .hazard      (hazard)
    );

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        stall        = 1'b0;
        halted       = 1'b0;
        state_next   = state;
        drain_next   = drain_cnt;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_next   = RUN;
            drain_next   = '0;
        end else begin
            halted = (state == HALTED);
            if (mem_shouldBranch) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (state != RUN) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end else if (hazard) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                stall       = 1'b1;
            end
            case (state)
                RUN: begin
                    // A taken branch pushes drain entry out by one cycle.
                    if (halt_req && !mem_shouldBranch) begin
                        state_next = DRAIN;
                        drain_next = '0;
                    end
                end
                DRAIN: begin
                    if (!halt_req) begin
                        state_next = RUN;
                        drain_next = '0;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state_next = HALTED;
                        drain_next = '0;
                    end else begin
                        drain_next = drain_cnt + DW'(1);
                    end
                end
                HALTED: begin
                    if (!halt_req) state_next = RUN;
                end
                default: begin
                    state_next = RUN;
                    drain_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            stall_count <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: one DUT per register-file mode,
// scenario tasks plus a randomized run against a behavioural model.
module tb_pipeline_controller;

    localparam int DRAIN = 3;
    localparam logic [31:0] NOP = 32'h0;
    localparam logic [31:0] LW2 = {6'h23, 5'd1, 5'd2, 16'd0};
    localparam logic [31:0] ADD3 = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] ADDI0 = {6'h08, 5'd0, 5'd0, 16'd5};
    localparam logic [31:0] ADD300 = {6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] ADD6 = {6'h00, 5'd5, 5'd7, 5'd6, 5'd0, 6'h20};
    localparam logic [6:0] RST_O = 7'b0011100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [31:0] id_instruction = '0;
    logic mem_shouldBranch = 1'b0;
    logic halt_req = 1'b0;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, stall, halted}
    wire [6:0] obs0;
    wire [6:0] obs1;
    wire [31:0] cnt0;
    wire [31:0] cnt1;

    int total = 0;
    int bad = 0;

    int q[2][3];
    int mode[2];
    int dcnt[2];
    longint scnt[2];
    logic [6:0] exp_o[2];
    int cur_dest;

    always #5 clock = ~clock;

    pipeline_controller #(.REGFILE_WRITE_THROUGH(1'b1), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut_wt (
        .clock(clock), .reset(reset), .id_instruction(id_instruction),
        .mem_shouldBranch(mem_shouldBranch), .halt_req(halt_req),
        .pc_write(obs0[6]), .if_id_write(obs0[5]), .if_id_flush(obs0[4]),
        .id_ex_flush(obs0[3]), .ex_mem_flush(obs0[2]), .stall(obs0[1]),
        .halted(obs0[0]), .stall_count(cnt0)
    );

    pipeline_controller #(.REGFILE_WRITE_THROUGH(1'b0), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut_nwt (
        .clock(clock), .reset(reset), .id_instruction(id_instruction),
        .mem_shouldBranch(mem_shouldBranch), .halt_req(halt_req),
        .pc_write(obs1[6]), .if_id_write(obs1[5]), .if_id_flush(obs1[4]),
        .id_ex_flush(obs1[3]), .ex_mem_flush(obs1[2]), .stall(obs1[1]),
        .halted(obs1[0]), .stall_count(cnt1)
    );

    function automatic int dest_of(input logic [31:0] i);
        case (i[31:26])
            6'h00: return int'(i[15:11]);
            6'h23, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return int'(i[20:16]);
            default: return 0;
        endcase
    endfunction

    function automatic bit rt_src(input logic [31:0] i);
        return i[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2B};
    endfunction

    // Expected outputs from the in-flight producer list and the mode.
    task automatic model_eval();
        int rs, rt, n;
        bit ru, hz;
        bit h;
        rs = int'(id_instruction[25:21]);
        rt = int'(id_instruction[20:16]);
        ru = rt_src(id_instruction);
        cur_dest = dest_of(id_instruction);
        for (int k = 0; k < 2; k++) begin
            n = (k == 0) ? 2 : 3;
            hz = 1'b0;
            for (int j = 0; j < n; j++)
                if (q[k][j] != 0 && (q[k][j] == rs || (ru && q[k][j] == rt))) hz = 1'b1;
            h = (mode[k] == 2);
            if (reset) exp_o[k] = RST_O;
            else if (mem_shouldBranch) exp_o[k] = {5'b11111, 1'b0, h};
            else if (mode[k] != 0) exp_o[k] = {5'b00010, 1'b0, h};
            else if (hz) exp_o[k] = 7'b0001010;
            else exp_o[k] = 7'b1100000;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                q[k] = '{0, 0, 0};
                mode[k] = 0;
                dcnt[k] = 0;
                scnt[k] = 0;
            end else begin
                q[k][2] = q[k][1];
                q[k][1] = exp_o[k][2] ? 0 : q[k][0];
                q[k][0] = exp_o[k][3] ? 0 : cur_dest;
                if (exp_o[k][1] && scnt[k] < 64'hFFFF_FFFF) scnt[k]++;
                if (mode[k] == 0) begin
                    if (halt_req && !mem_shouldBranch) begin
                        mode[k] = 1;
                        dcnt[k] = 0;
                    end
                end else if (mode[k] == 1) begin
                    if (!halt_req) begin
                        mode[k] = 0;
                        dcnt[k] = 0;
                    end else if (dcnt[k] == DRAIN - 1) begin
                        mode[k] = 2;
                        dcnt[k] = 0;
                    end else begin
                        dcnt[k]++;
                    end
                end else if (!halt_req) begin
                    mode[k] = 0;
                end
            end
        end
    endtask

    task automatic drive(input logic [31:0] ins, input bit br, input bit hr, input bit rst);
        id_instruction = ins;
        mem_shouldBranch = br;
        halt_req = hr;
        reset = rst;
        #4;
        model_eval();
    endtask

    task automatic adv();
        model_update();
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [6:0] o;
        for (int i = 0; i < 2; i++) begin
            drive($urandom, 1'($urandom), 1'($urandom), 1'b1);
            for (int k = 0; k < 2; k++) begin
                o = (k == 0) ? obs0 : obs1;
                total++;
                if (o !== RST_O) begin
                    bad++;
                    $display("FAIL reset_outs dut%0d: got %b want %b", k, o, RST_O);
                end
            end
            adv();
        end
        drive(NOP, 1'b0, 1'b0, 1'b0);
        total++;
        if (cnt0 !== 32'd0 || cnt1 !== 32'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d/%0d want 0/0", cnt0, cnt1);
        end
        total++;
        if (obs0 !== exp_o[0] || obs1 !== exp_o[1]) begin
            bad++;
            $display("FAIL reset_run: got %b/%b want %b/%b", obs0, obs1, exp_o[0], exp_o[1]);
        end
        adv();
    endtask

    task automatic test_load_use();
        logic [31:0] seq[$];
        seq = '{LW2, ADD3, ADD3, ADD3, ADD3, NOP, NOP};
        drive(NOP, 1'b0, 1'b0, 1'b1);
        adv();
        foreach (seq[i]) begin
            drive(seq[i], 1'b0, 1'b0, 1'b0);
            total++;
            if (obs0 !== exp_o[0] || obs1 !== exp_o[1]) begin
                bad++;
                $display("FAIL load_use c%0d: got %b/%b want %b/%b", i, obs0, obs1, exp_o[0], exp_o[1]);
            end
            if (i == 3) begin
                total++;
                if (obs0[6] !== 1'b1 || obs1[6] !== 1'b0) begin
                    bad++;
                    $display("FAIL load_use_issue: pc_write got %b/%b want 1/0", obs0[6], obs1[6]);
                end
            end
            adv();
        end
        drive(NOP, 1'b0, 1'b0, 1'b0);
        total++;
        if (cnt0 !== 32'd2 || cnt1 !== 32'd3) begin
            bad++;
            $display("FAIL load_use_count: got %0d/%0d want 2/3", cnt0, cnt1);
        end
        adv();
    endtask

    task automatic test_zero_reg();
        logic [31:0] seq[$];
        seq = '{ADDI0, ADD300, ADD300, NOP};
        drive(NOP, 1'b0, 1'b0, 1'b1);
        adv();
        foreach (seq[i]) begin
            drive(seq[i], 1'b0, 1'b0, 1'b0);
            total++;
            if (obs0 !== 7'b1100000 || obs1 !== 7'b1100000) begin
                bad++;
                $display("FAIL zero_reg c%0d: got %b/%b want 1100000", i, obs0, obs1);
            end
            adv();
        end
        drive(NOP, 1'b0, 1'b0, 1'b0);
        total++;
        if (cnt0 !== 32'd0 || cnt1 !== 32'd0) begin
            bad++;
            $display("FAIL zero_reg_count: got %0d/%0d want 0/0", cnt0, cnt1);
        end
        adv();
    endtask

    task automatic test_branch_hazard();
        drive(NOP, 1'b0, 1'b0, 1'b1);
        adv();
        drive(LW2, 1'b0, 1'b0, 1'b0);
        adv();
        drive(ADD3, 1'b1, 1'b0, 1'b0);
        total++;
        if ((obs0 & 7'b1011110) !== 7'b1011100 || (obs1 & 7'b1011110) !== 7'b1011100) begin
            bad++;
            $display("FAIL branch_flush: got %b/%b want 1x1110x", obs0, obs1);
        end
        adv();
        drive(ADD3, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs0[1] !== 1'b0 || obs1[1] !== 1'b0 || obs0 !== exp_o[0]) begin
            bad++;
            $display("FAIL branch_sb_clear: stall got %b/%b want 0/0", obs0[1], obs1[1]);
        end
        total++;
        if (cnt0 !== 32'd0 || cnt1 !== 32'd0) begin
            bad++;
            $display("FAIL branch_count: got %0d/%0d want 0/0", cnt0, cnt1);
        end
        adv();
    endtask

    task automatic test_halt_drain();
        bit hr;
        drive(NOP, 1'b0, 1'b0, 1'b1);
        adv();
        for (int i = 0; i < 8; i++) begin
            hr = (i < 6);
            drive(ADD6, 1'b0, hr, 1'b0);
            total++;
            if (obs0[0] !== 1'((i >= 4) && (i <= 6)) || obs1[0] !== obs0[0]) begin
                bad++;
                $display("FAIL halt_flag c%0d: got %b/%b want %b", i, obs0[0], obs1[0], (i >= 4) && (i <= 6));
            end
            total++;
            if (obs0 !== exp_o[0] || obs1 !== exp_o[1]) begin
                bad++;
                $display("FAIL halt_outs c%0d: got %b/%b want %b/%b", i, obs0, obs1, exp_o[0], exp_o[1]);
            end
            if (i == 7) begin
                total++;
                if (obs0[6:5] !== 2'b11 || obs1[6:5] !== 2'b11) begin
                    bad++;
                    $display("FAIL halt_resume: got %b/%b want 11/11", obs0[6:5], obs1[6:5]);
                end
            end
            adv();
        end
    endtask

    task automatic test_reset_in_drain();
        drive(NOP, 1'b0, 1'b0, 1'b1);
        adv();
        drive(LW2, 1'b0, 1'b0, 1'b0);
        adv();
        drive(ADD3, 1'b0, 1'b1, 1'b0);
        adv();
        drive(ADD3, 1'b0, 1'b1, 1'b0);
        total++;
        if (cnt0 !== 32'd1 || cnt1 !== 32'd1 || obs0 !== 7'b0001000) begin
            bad++;
            $display("FAIL drain_entry: got %b cnt %0d/%0d want 0001000 cnt 1/1", obs0, cnt0, cnt1);
        end
        adv();
        drive(ADD3, 1'b0, 1'b1, 1'b1);
        total++;
        if (obs0 !== RST_O || obs1 !== RST_O) begin
            bad++;
            $display("FAIL drain_reset: got %b/%b want %b", obs0, obs1, RST_O);
        end
        adv();
        drive(ADD3, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs0 !== 7'b1100000 || obs1 !== 7'b1100000 || cnt0 !== 32'd0 || cnt1 !== 32'd0) begin
            bad++;
            $display("FAIL drain_reset_run: got %b/%b cnt %0d/%0d want 1100000 cnt 0", obs0, obs1, cnt0, cnt1);
        end
        adv();
    endtask

    task automatic test_random();
        logic [5:0] ops[12];
        logic [31:0] ins;
        bit hr = 1'b0;
        bit br, rst;
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h02};
        for (int i = 0; i < 500; i++) begin
            ins = {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'd0, 6'h20};
            if ($urandom_range(0, 15) == 0) ins = NOP;
            if ($urandom_range(0, 19) == 0) hr = ~hr;
            br = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            drive(ins, br, hr, rst);
            total++;
            if (obs0 !== exp_o[0] || obs1 !== exp_o[1]) begin
                bad++;
                $display("FAIL random_outs c%0d: got %b/%b want %b/%b", i, obs0, obs1, exp_o[0], exp_o[1]);
            end
            total++;
            if (cnt0 !== 32'(scnt[0]) || cnt1 !== 32'(scnt[1])) begin
                bad++;
                $display("FAIL random_count c%0d: got %0d/%0d want %0d/%0d", i, cnt0, cnt1, scnt[0], scnt[1]);
            end
            adv();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            q[k] = '{0, 0, 0};
            mode[k] = 0;
            dcnt[k] = 0;
            scnt[k] = 0;
        end
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_hazard();
        test_halt_drain();
        test_reset_in_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central sequencing unit for the five-stage CPU (IF, ID, EX, MEM, WB).
- Tracks the destination registers of in-flight instructions in a small scoreboard.
- Detects RAW hazards on the instruction held in the IF/ID register, and drives stall and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Handles redirects from the MEM-stage branch (mem_shouldBranch), plus an external halt/drain request.
- Sits in Cpu beside IdStage; its outputs gate the stage and pipeline-register write enables.

Parameters:
REGFILE_WRITE_THROUGH, 1, 1 = register file writes in the first half-cycle, so a WB producer never hazards; 0 = the WB entry also stalls.
DRAIN_CYCLES, 3, cycles spent in DRAIN before halted asserts (EX+MEM+WB empty).
CNT_W, 32, width of the stall_count performance counter.

Ports:
clock  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
id_instruction  in  32  instruction currently in IF/ID
mem_shouldBranch  in  1  branch taken, resolved in MEM this cycle
halt_req  in  1  level request to drain and freeze the pipeline
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_flush  out  1  ID/EX loads a bubble
ex_mem_flush  out  1  EX/MEM loads a bubble
stall  out  1  RAW stall active this cycle
halted  out  1  pipeline drained and frozen
stall_count  out  CNT_W  number of RAW stall cycles since reset

Behaviour:
- All state is clocked on the clock rising edge; reset is synchronous and active-high.
- While reset is high, combinational outputs are forced: pc_write=0, if_id_write=0, all flushes=1, stall=0, halted=0.
- On reset: state=RUN, scoreboard entries invalid, drain counter=0, stall_count=0.
- Decode of id_instruction:
  - Sources: rs, and rt only for R-type, beq/bne and stores.
  - Destination: rd for R-type (opcode 0); rt for loads and ALU-immediate; none for branches, stores, j and NOP (all-zero word).
  - Destination or source $0 never participates in a hazard.
- Scoreboard: three entries {valid, dest[4:0]} named sb_ex, sb_mem and sb_wb, shifted every cycle:
  - sb_wb <= sb_mem
  - sb_mem <= ex_mem_flush ? invalid : sb_ex
  - sb_ex <= (id_ex_flush) ? invalid : decoded ID destination
- hazard = any ID source equals the dest of a valid sb_ex or sb_mem entry, or of sb_wb when REGFILE_WRITE_THROUGH=0.
- Priority: reset > mem_shouldBranch > state DRAIN/HALTED > hazard > normal.
- RUN, branch taken:
  - pc_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - stall=0 even if hazard is set; stall_count is not incremented.
- RUN, hazard:
  - pc_write=0, if_id_write=0, id_ex_flush=1, stall=1.
  - stall_count increments by 1 and saturates at all-ones.
- RUN, normal: pc_write=1, if_id_write=1, no flushes.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when halt_req=1 and no branch is taken this cycle. A taken branch defers entry to DRAIN by one cycle.
  - DRAIN:
    - pc_write=0, if_id_write=0, id_ex_flush=1 (the ID instruction is held, not lost).
    - Counter increments each cycle; moves to HALTED when counter == DRAIN_CYCLES-1.
    - A branch resolving during DRAIN still drives all flushes and pc_write=1 (redirect recorded).
    - halt_req falling during DRAIN returns to RUN next cycle and clears the counter.
  - HALTED: halted=1, pc_write=0, if_id_write=0, id_ex_flush=1. Returns to RUN on halt_req=0 the next cycle.
- Latency: hazard detection is same-cycle combinational from id_instruction and the scoreboard. Every output is a function of current state and inputs only.
- Reset mid-DRAIN or mid-HALTED returns to RUN with the scoreboard cleared.

Decomposition:
- Package pipeline_ctrl_pkg:
  - Opcode/funct constants (R-type, lw, sw, beq, bne, addi, andi, ori, slti, lui, j).
  - State enum {RUN, DRAIN, HALTED}.
  - sb_entry_t struct.
  - Decode functions get_dest() and uses_rt().
- One sub-module, hazard_scoreboard, contains the three-entry shift register plus the hazard compare. The controller holds the FSM, priority logic and counters.

Test Plan:
- lw $2,0($1) then add $3,$2,$4 with write-through=1 -> stall=1 for 2 cycles; pc_write=0 in both; stall_count=2; add proceeds in cycle 3.
- Same pair with REGFILE_WRITE_THROUGH=0 -> 3 stall cycles; stall_count=3.
- addi $0,$0,5 then add $3,$0,$0 -> no stall; stall_count stays 0.
- Hazard pending and mem_shouldBranch=1 in the same cycle -> stall=0; if_id_flush, id_ex_flush and ex_mem_flush all =1; pc_write=1; stall_count unchanged; scoreboard EX/MEM entries invalid next cycle.
- halt_req=1 held -> 3 DRAIN cycles, then halted=1 on cycle 4. Drop halt_req -> RUN next cycle and the held ID instruction issues.
- reset asserted during the second DRAIN cycle -> next cycle RUN, halted=0, stall_count=0, scoreboard empty.
